// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM states,
// geometry constants and the fetch-address field helpers.
package instruction_cache_pkg;

   localparam int DEFAULT_INDEX_BITS = 3;
   localparam int BYTE_OFFSET_BITS   = 4;
   localparam int WORD_SEL_BITS      = 2;
   localparam int LINE_ADDR_BITS     = 32 - BYTE_OFFSET_BITS;
   localparam int LINE_BITS          = 128;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, FETCH, FILL} state_t;

   function automatic logic [LINE_ADDR_BITS-1:0] line_address(input logic [31:0] address);
      return address[31:BYTE_OFFSET_BITS];
   endfunction

   function automatic logic [WORD_SEL_BITS-1:0] word_offset(input logic [31:0] address);
      return address[BYTE_OFFSET_BITS-1:2];
   endfunction

   // Word 0 of a line sits in the least significant 32 bits.
   function automatic logic [31:0] select_word(input logic [LINE_BITS-1:0] line,
                                               input logic [WORD_SEL_BITS-1:0] offset);
      return line[offset*32 +: 32];
   endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side and main-memory-side signals of the instruction cache.
// The cache is the slave; the IF stage plus memory form the master side.
interface instruction_cache_if;
   import instruction_cache_pkg::*;

   logic                      read;
   logic [31:0]               address;
   logic                      flush;
   logic [31:0]               instruction;
   logic                      busywait;
   logic                      mem_read;
   logic [LINE_ADDR_BITS-1:0] mem_address;
   logic [LINE_BITS-1:0]      mem_readdata;
   logic                      mem_busywait;

   modport slave (
      input  read, address, flush, mem_readdata, mem_busywait,
      output instruction, busywait, mem_read, mem_address
   );

   modport master (
      output read, address, flush, mem_readdata, mem_busywait,
      input  instruction, busywait, mem_read, mem_address
   );

endinterface

// File: rtl/instruction_cache_line_store.sv
// Valid/tag/data arrays for the cache lines: combinational read port,
// one write port used by refills, and a bulk valid clear for fence.i.
module icache_line_store
   import instruction_cache_pkg::*;
#(
   parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
   parameter int TAG_BITS   = LINE_ADDR_BITS - DEFAULT_INDEX_BITS
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [LINE_BITS-1:0]  rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [LINE_BITS-1:0]  wr_data,
   input  logic                  clear
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]     valid;
   logic [TAG_BITS-1:0]  tags [LINES];
   logic [LINE_BITS-1:0] lines [LINES];

   // Only the valid bits need resetting; stale tags/data are never trusted.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid <= '0;
      end else begin
         if (clear) valid <= '0;
         if (wr_en) valid[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_index]  <= wr_tag;
         lines[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_index];
   assign rd_tag   = tags[rd_index];
   assign rd_data  = lines[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with 16-byte lines; reset is
// synchronous and active-low. Misses refill a whole line from main memory.
module instruction_cache
   import instruction_cache_pkg::*;
#(
   parameter int          INDEX_BITS = DEFAULT_INDEX_BITS,
   parameter logic [31:0] NOP_INSTR  = instruction_cache_pkg::NOP_INSTR
)(
   input  logic                 clk,
   input  logic                 reset,
   instruction_cache_if.slave   bus
);

   localparam int TAG_BITS = LINE_ADDR_BITS - INDEX_BITS;

   state_t                    state, next_state;
   logic [LINE_ADDR_BITS-1:0] cur_line, miss_line;
   logic [INDEX_BITS-1:0]     cur_index;
   logic [TAG_BITS-1:0]       cur_tag;
   logic                      rd_valid;
   logic [TAG_BITS-1:0]       rd_tag;
   logic [LINE_BITS-1:0]      rd_data, fill_data;
   logic                      hit;

   assign cur_line  = line_address(bus.address);
   assign cur_index = cur_line[INDEX_BITS-1:0];
   assign cur_tag   = cur_line[LINE_ADDR_BITS-1:INDEX_BITS];
   assign hit       = (state == IDLE) && bus.read && rd_valid && (rd_tag == cur_tag);

   icache_line_store #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) line_store (
      .clk      (clk),
      .reset    (reset),
      .rd_index (cur_index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (state == FILL),
      .wr_index (miss_line[INDEX_BITS-1:0]),
      .wr_tag   (miss_line[LINE_ADDR_BITS-1:INDEX_BITS]),
      .wr_data  (fill_data),
      .clear    ((state == IDLE) && bus.flush)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // The refill works from the latched line address, so PC churn during a miss is harmless.
   always_ff @(posedge clk) begin
      if ((state == IDLE) && bus.read && !hit) miss_line <= cur_line;
      if ((state == FETCH) && !bus.mem_busywait) fill_data <= bus.mem_readdata;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.read && !hit)  next_state = FETCH;
         FETCH:   if (!bus.mem_busywait) next_state = FILL;
         FILL:                           next_state = IDLE;
         default:                        next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.instruction = NOP_INSTR;
      bus.busywait    = 1'b0;
      bus.mem_read    = 1'b0;
      if (reset) begin
         case (state)
            IDLE: begin
               if (hit)           bus.instruction = select_word(rd_data, word_offset(bus.address));
               else if (bus.read) bus.busywait    = 1'b1;
            end
            FETCH: begin
               bus.mem_read = 1'b1;
               bus.busywait = 1'b1;
            end
            FILL:    bus.busywait = 1'b1;
            default: bus.busywait = 1'b0;
         endcase
      end
   end

   assign bus.mem_address = miss_line;

endmodule

// File: tb/tb_instruction_cache.sv
// Randomized self-checking bench for instruction_cache: a line-level cache
// model and a variable-latency main memory model live in the bench.
module tb_instruction_cache;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic reset;
   int   testsRun = 0;
   int   testsFailed = 0;
   int   memLat = 3;
   int   memCnt = 0;

   bit          refValid [8];
   logic [27:0] refLine  [8];

   instruction_cache_if bus ();

   instruction_cache dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Main memory content: every word holds its word address plus one.
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return (addr >> 2) + 32'd1;
   endfunction

   always @(posedge clk) begin
      if (bus.mem_read) memCnt <= memCnt + 1;
      else              memCnt <= 0;
   end

   assign bus.mem_busywait = !(bus.mem_read && (memCnt == memLat - 1));
   assign bus.mem_readdata = {memWord({bus.mem_address, 4'hC}), memWord({bus.mem_address, 4'h8}),
                              memWord({bus.mem_address, 4'h4}), memWord({bus.mem_address, 4'h0})};

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < 8; i++) refValid[i] = 1'b0;
   endtask

   task automatic idleCycle();
      @(posedge clk); #1;
      bus.read = 1'b0; bus.flush = 1'b0;
      @(negedge clk);
      checkOutput("idle_busywait", {31'd0, bus.busywait}, 32'd0);
      checkOutput("idle_instr", bus.instruction, NOP);
      checkOutput("idle_mem_read", {31'd0, bus.mem_read}, 32'd0);
   endtask

   // One fetch request held until it returns data; the model decides hit/miss.
   task automatic applyStimulus(input logic [31:0] addr, input bit fl, input bit doChurn,
                                input logic [31:0] churnAddr);
      logic [31:0] cur;
      logic [27:0] missLine;
      bit          done, flushNow, filled;
      int          busy, fetch, idx;
      @(posedge clk); #1;
      bus.read = 1'b1; bus.address = addr; bus.flush = fl;
      cur = addr; flushNow = fl; done = 0;
      @(negedge clk);
      while (!done) begin
         idx = int'(cur[6:4]);
         if (refValid[idx] && refLine[idx] == cur[31:4]) begin
            checkOutput("hit_busywait", {31'd0, bus.busywait}, 32'd0);
            checkOutput("hit_instr", bus.instruction, memWord(cur));
            checkOutput("hit_mem_read", {31'd0, bus.mem_read}, 32'd0);
            if (flushNow) clearModel();
            done = 1;
         end else begin
            checkOutput("miss_busywait", {31'd0, bus.busywait}, 32'd1);
            checkOutput("miss_instr", bus.instruction, NOP);
            if (flushNow) clearModel();
            flushNow = 0;
            missLine = cur[31:4];
            busy = 1; fetch = 0; filled = 0;
            for (int c = 0; c < 64 && !filled; c++) begin
               @(posedge clk); #1;
               bus.flush = 1'b0;
               if (doChurn && c == 0) begin
                  bus.address = churnAddr; cur = churnAddr;
               end
               @(negedge clk);
               busy++;
               checkOutput("refill_busywait", {31'd0, bus.busywait}, 32'd1);
               checkOutput("refill_instr", bus.instruction, NOP);
               if (bus.mem_read) begin
                  fetch++;
                  checkOutput("mem_address", {4'd0, bus.mem_address}, {4'd0, missLine});
               end else if (fetch > 0) begin
                  filled = 1;
               end
            end
            checkOutput("miss_busy_cycles", busy, memLat + 2);
            checkOutput("miss_fetch_cycles", fetch, memLat);
            refValid[int'(missLine[2:0])] = 1'b1;
            refLine[int'(missLine[2:0])]  = missLine;
            @(posedge clk); #1;
            @(negedge clk);
         end
      end
   endtask

   task automatic resetMidMiss();
      memLat = 4;
      @(posedge clk); #1;
      bus.read = 1'b1; bus.address = 32'h40; bus.flush = 1'b0;
      @(negedge clk);
      checkOutput("rst_miss_busywait", {31'd0, bus.busywait}, 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rst_fetch_mem_read", {31'd0, bus.mem_read}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_low_busywait", {31'd0, bus.busywait}, 32'd0);
      checkOutput("rst_low_instr", bus.instruction, NOP);
      @(posedge clk); #1;
      reset = 1'b1; bus.read = 1'b0;
      @(negedge clk);
      checkOutput("rst_after_mem_read", {31'd0, bus.mem_read}, 32'd0);
      checkOutput("rst_after_busywait", {31'd0, bus.busywait}, 32'd0);
      clearModel();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a, c;
      clearModel();
      reset = 1'b0; bus.read = 1'b1; bus.address = 32'h0; bus.flush = 1'b0;
      repeat (2) begin
         @(negedge clk);
         checkOutput("reset_busywait", {31'd0, bus.busywait}, 32'd0);
         checkOutput("reset_instr", bus.instruction, NOP);
         checkOutput("reset_mem_read", {31'd0, bus.mem_read}, 32'd0);
      end
      @(posedge clk); #1;
      reset = 1'b1; bus.read = 1'b0;

      memLat = 3;
      applyStimulus(32'h0, 0, 0, 32'h0);
      applyStimulus(32'h4, 0, 0, 32'h0);
      applyStimulus(32'h8, 0, 0, 32'h0);
      applyStimulus(32'hC, 0, 0, 32'h0);
      applyStimulus(32'h80, 0, 0, 32'h0);
      applyStimulus(32'h0, 0, 0, 32'h0);
      applyStimulus(32'h4, 1, 0, 32'h0);
      applyStimulus(32'h4, 0, 0, 32'h0);
      resetMidMiss();
      memLat = 2;
      applyStimulus(32'h0, 0, 1, 32'h10);
      idleCycle();

      for (int n = 0; n < 150; n++) begin
         a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4)
           | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         c = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
         memLat = int'($urandom_range(1, 4));
         if ($urandom_range(0, 7) == 0) idleCycle();
         applyStimulus(a, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, c);
      end
      idleCycle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
